work_shifter: RTL

- Host-side serial transmitter for the work-load interface of hashcore (din/shift).
- Accepts one parallel work word per valid/ready handshake: midstate IV plus data2, with the initial nonce in the top 32 bits.
- Serializes the word onto din while holding shift high for exactly DATA_WIDTH cycles, then keeps shift low for a guaranteed gap, so the core's shift-falling-edge nonce load and cycle restart happen once per frame.
- Sits between the serial/comms front end and one or more hashcore instances (fan-out of din/shift).

---
 rtl/work_pkg.sv | 24 ++
 rtl/work_skid_buf.sv | 45 ++++
 rtl/work_shifter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/work_pkg.sv
// Shared definitions for the hashcore work-load path.
//   DATA_WIDTH   : default frame length (midstate + data2).
//   *_LSB / *_W  : field positions inside a work word; the initial nonce
//                  occupies the top 32 bits of data2.
//   state_t      : serializer state encoding.
package work_pkg;

    localparam int MIDSTATE_W   = 256;
    localparam int DATA2_W      = 128;
    localparam int NONCE_W      = 32;

    localparam int DATA_WIDTH   = MIDSTATE_W + DATA2_W;

    localparam int MIDSTATE_LSB = 0;
    localparam int DATA2_LSB    = MIDSTATE_LSB + MIDSTATE_W;
    localparam int NONCE_LSB    = DATA_WIDTH - NONCE_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/work_skid_buf.sv
// One-entry valid/ready holding register in front of the serializer.
//   clk, rst_n          : clock, async active-low reset
//   in_data, in_valid   : upstream word and its valid
//   in_ready            : buffer empty; driven only from the valid flop
//   take                : consumer drains the held word this cycle
//   out_data, out_valid : held word and its valid
module work_skid_buf #(
    parameter int WIDTH = 384
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             take,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    // take only happens while full and a handshake only while empty, so the
    // two never coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else if (take) begin
            valid_q <= 1'b0;
        end else if (in_valid && in_ready) begin
            valid_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            data_q <= in_data;
        end
    end

    assign in_ready  = ~valid_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/work_shifter.sv
// Serial work loader for hashcore: takes one parallel work word per
// valid/ready handshake and streams it out on din with shift held high for
// DATA_WIDTH cycles, followed by a guaranteed low gap on shift.
//   hash_clk, rst_n   : clock, async active-low reset
//   work_data/valid   : parallel work word and its valid
//   work_ready        : holding buffer empty
//   din, shift        : registered serial data and shift enable
//   busy              : frame or gap in progress
//   load_done         : one-cycle strobe after each completed frame
//   frames_sent       : completed frame count, wraps
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | shift low; loads the buffered word when one is held
// ST_SHIFT | shift high, one bit per cycle, bit_cnt counts down to 0
// ST_GAP   | shift low for MIN_GAP cycles, gap_cnt counts down to 0
module work_shifter #(
    parameter int DATA_WIDTH = work_pkg::DATA_WIDTH,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int MIN_GAP    = 2
) (
    input  logic                  hash_clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] work_data,
    input  logic                  work_valid,
    output logic                  work_ready,
    output logic                  din,
    output logic                  shift,
    output logic                  busy,
    output logic                  load_done,
    output logic [15:0]           frames_sent
);

    import work_pkg::*;

    localparam int               CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [7:0]       GAP_LOAD = 8'(MIN_GAP - 1);

    logic [DATA_WIDTH-1:0] buf_data;
    logic                  buf_valid;
    logic                  buf_take;

    work_skid_buf #(.WIDTH(DATA_WIDTH)) u_buf (
        .clk       (hash_clk),
        .rst_n     (rst_n),
        .in_data   (work_data),
        .in_valid  (work_valid),
        .in_ready  (work_ready),
        .take      (buf_take),
        .out_data  (buf_data),
        .out_valid (buf_valid)
    );

    state_t                state_q,     state_d;
    logic [DATA_WIDTH-1:0] sreg_q,      sreg_d;
    logic [CNT_W-1:0]      bit_cnt_q,   bit_cnt_d;
    logic [7:0]            gap_cnt_q,   gap_cnt_d;
    logic                  din_q,       din_d;
    logic                  shift_q,     shift_d;
    logic                  load_done_q, load_done_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;

    always_ff @(posedge hash_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            din_q       <= 1'b0;
            shift_q     <= 1'b0;
            load_done_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            din_q       <= din_d;
            shift_q     <= shift_d;
            load_done_q <= load_done_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Payload register needs no reset: it is only observed after a load.
    always_ff @(posedge hash_clk) begin
        sreg_q <= sreg_d;
    end

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        din_d       = din_q;
        shift_d     = shift_q;
        load_done_d = 1'b0;
        frame_cnt_d = frame_cnt_q;
        buf_take    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (buf_valid) begin
                    buf_take  = 1'b1;
                    sreg_d    = buf_data;
                    din_d     = MSB_FIRST ? buf_data[DATA_WIDTH-1] : buf_data[0];
                    shift_d   = 1'b1;
                    bit_cnt_d = LAST_BIT;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_q == '0) begin
                    shift_d     = 1'b0;
                    din_d       = 1'b0;
                    load_done_d = 1'b1;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    gap_cnt_d   = GAP_LOAD;
                    state_d     = ST_GAP;
                end else begin
                    // din always shows the current end bit of sreg, so the
                    // next bit is the neighbour of that end before shifting.
                    if (MSB_FIRST) begin
                        sreg_d = {sreg_q[DATA_WIDTH-2:0], 1'b0};
                        din_d  = sreg_q[DATA_WIDTH-2];
                    end else begin
                        sreg_d = {1'b0, sreg_q[DATA_WIDTH-1:1]};
                        din_d  = sreg_q[1];
                    end
                    bit_cnt_d = bit_cnt_q - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign din         = din_q;
    assign shift       = shift_q;
    assign busy        = (state_q != ST_IDLE);
    assign load_done   = load_done_q;
    assign frames_sent = frame_cnt_q;

endmodule
